flex_scan_counter: RTL

Two-dimensional, parametrised successor to the single-stage flex counter: a cascaded column/row counter with programmable per-dimension rollover values, registered rollover, frame-done and border flags. It sits in the Sobel pipeline front end, tracks the raster position of each accepted pixel, and tells the convolution and output stages when a pixel lies on the 3x3 window border or ends a line or frame.

---
 rtl/flex_scan_counter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/flex_scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : flex_scan_counter
// Description : Cascaded column/row raster position counter with programmable
//               per-dimension rollover values. Outputs the 1-based position of
//               the current pixel with registered line-end, last-row,
//               frame-done and window-border flags that are aligned with the
//               position outputs.
// Ports       : clk                - rising-edge clock
//               n_rst              - synchronous active-low reset
//               clear              - synchronous return to idle (beats enable)
//               count_enable       - advance by one pixel this cycle
//               col_rollover_val   - last column index (0 treated as 1)
//               row_rollover_val   - last row index (0 treated as 1)
//               col_out / row_out  - current position, 0 when idle
//               active             - position is valid
//               col_rollover_flag  - pixel is last of its line
//               row_rollover_flag  - pixel is on the last row
//               frame_done         - pixel is last of the frame
//               border_flag        - pixel within BORDER of any frame edge
// Revision    : 1.0 - initial release
// ============================================================================
module flex_scan_counter #(
    parameter int COL_BITS = 10,
    parameter int ROW_BITS = 10,
    parameter int BORDER   = 1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                count_enable,
    input  logic [COL_BITS-1:0] col_rollover_val,
    input  logic [ROW_BITS-1:0] row_rollover_val,
    output logic [COL_BITS-1:0] col_out,
    output logic [ROW_BITS-1:0] row_out,
    output logic                active,
    output logic                col_rollover_flag,
    output logic                row_rollover_flag,
    output logic                frame_done,
    output logic                border_flag
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    localparam logic [COL_BITS:0] c_col_border = (COL_BITS+1)'(BORDER);
    localparam logic [ROW_BITS:0] c_row_border = (ROW_BITS+1)'(BORDER);

    logic [0:0]          r_state;
    logic [COL_BITS-1:0] r_col;
    logic [ROW_BITS-1:0] r_row;
    logic                r_col_flag;
    logic                r_row_flag;
    logic                r_frame_done;
    logic                r_border;

    logic [0:0]          w_next_state;
    logic [COL_BITS-1:0] w_next_col;
    logic [ROW_BITS-1:0] w_next_row;
    logic [COL_BITS-1:0] w_col_rv;
    logic [ROW_BITS-1:0] w_row_rv;
    logic                w_scan;
    logic                w_col_flag;
    logic                w_row_flag;
    logic                w_border;
    logic [COL_BITS:0]   w_col_lim;
    logic [ROW_BITS:0]   w_row_lim;
    logic                w_col_edge;
    logic                w_row_edge;

    // A programmed rollover of 0 would make a line/frame of zero pixels;
    // clamp it to a single-pixel dimension instead.
    assign w_col_rv = (col_rollover_val == '0) ? COL_BITS'(1) : col_rollover_val;
    assign w_row_rv = (row_rollover_val == '0) ? ROW_BITS'(1) : row_rollover_val;

    // ------------------------------------------------------------------------
    // State register (position and flags are all registered together)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_col_flag   <= 1'b0;
            r_row_flag   <= 1'b0;
            r_frame_done <= 1'b0;
            r_border     <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_col        <= w_next_col;
            r_row        <= w_next_row;
            r_col_flag   <= w_col_flag;
            r_row_flag   <= w_row_flag;
            r_frame_done <= w_col_flag & w_row_flag;
            r_border     <= w_border;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / next-position logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_col   = r_col;
        w_next_row   = r_row;
        if (clear) begin
            w_next_state = S_IDLE;
            w_next_col   = '0;
            w_next_row   = '0;
        end else if (count_enable) begin
            if (r_state == S_IDLE) begin
                w_next_state = S_SCAN;
                w_next_col   = COL_BITS'(1);
                w_next_row   = ROW_BITS'(1);
            end else if (r_col >= w_col_rv) begin
                // ">=" so a rollover value lowered below the current count
                // wraps on the next step instead of running to binary wrap.
                w_next_col = COL_BITS'(1);
                if (r_row >= w_row_rv) begin
                    w_next_row = ROW_BITS'(1);
                end else begin
                    w_next_row = r_row + ROW_BITS'(1);
                end
            end else begin
                w_next_col = r_col + COL_BITS'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Flag logic, evaluated on the next position so the registered flags line
    // up with the registered position. Recomputed every cycle, so rollover
    // value changes show up even while stalled.
    // ------------------------------------------------------------------------
    always_comb begin
        w_scan     = (w_next_state == S_SCAN);
        w_col_flag = w_scan && (w_next_col >= w_col_rv);
        w_row_flag = w_scan && (w_next_row >= w_row_rv);

        // Far-edge limit computed one bit wider; a borrow (MSB set) means the
        // border covers the whole dimension.
        w_col_lim  = {1'b0, w_col_rv} - c_col_border;
        w_row_lim  = {1'b0, w_row_rv} - c_row_border;
        w_col_edge = ({1'b0, w_next_col} <= c_col_border) || w_col_lim[COL_BITS]
                     || ({1'b0, w_next_col} > w_col_lim);
        w_row_edge = ({1'b0, w_next_row} <= c_row_border) || w_row_lim[ROW_BITS]
                     || ({1'b0, w_next_row} > w_row_lim);
        w_border   = w_scan && (w_col_edge || w_row_edge);
    end

    assign col_out           = r_col;
    assign row_out           = r_row;
    assign active            = (r_state == S_SCAN);
    assign col_rollover_flag = r_col_flag;
    assign row_rollover_flag = r_row_flag;
    assign frame_done        = r_frame_done;
    assign border_flag       = r_border;

endmodule
`default_nettype wire
